// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/adjust sequencer with debounced inputs for the stopwatch counter
// Produces the count-enable tick, clear, adjust pulses and display blink gate.
module stopwatch_ctrl #(
  parameter int CLK_HZ          = 100000000,
  parameter int TICK_HZ         = 1,
  parameter int ADJ_HZ          = 2,
  parameter int BLINK_HZ        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       sw_adj,
  input  logic       sw_field,
  output logic       count_en,
  output logic       clr,
  output logic       adj_sec,
  output logic       adj_min,
  output logic       blink,
  output logic [1:0] state
);

  localparam int TICK_DIV  = CLK_HZ / TICK_HZ;
  localparam int ADJ_DIV   = CLK_HZ / ADJ_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int ADJ_W   = $clog2(ADJ_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [ADJ_W-1:0]   ADJ_LAST   = ADJ_W'(ADJ_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int IN_START = 0;
  localparam int IN_CLEAR = 1;
  localparam int IN_ADJ   = 2;
  localparam int IN_FIELD = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSE  = 2'b10,
    S_ADJUST = 2'b11
  } state_e;

  logic [3:0]      raw_in;
  logic [3:0]      sync1_q, sync2_q, db_q;
  logic [DB_W-1:0] db_cnt_q [4];
  logic [1:0]      db_prev_q, press_q;

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [ADJ_W-1:0]   adj_cnt_q, adj_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               count_en_q, count_en_d;
  logic               clr_q, clr_d;
  logic               adj_sec_q, adj_sec_d;
  logic               adj_min_q, adj_min_d;

  logic start_press, clear_press, adj_lvl, field_lvl, start_held;
  logic adj_fire;

  assign raw_in = {sw_field, sw_adj, btn_clear, btn_start};

  // Synchronize, debounce (restart on any bounce) and edge-detect each raw input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
      db_prev_q <= db_q[1:0];
      press_q   <= db_q[1:0] & ~db_prev_q;
    end
  end

  assign start_press = press_q[IN_START];
  assign clear_press = press_q[IN_CLEAR];
  assign start_held  = db_q[IN_START];
  assign adj_lvl     = db_q[IN_ADJ];
  assign field_lvl   = db_q[IN_FIELD];

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    adj_cnt_d   = '0;
    blink_cnt_d = '0;
    blink_d     = 1'b1;
    count_en_d  = 1'b0;
    clr_d       = 1'b0;
    adj_fire    = 1'b0;

    if (clear_press) begin
      state_d    = S_IDLE;
      clr_d      = 1'b1;
      tick_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (adj_lvl) begin
            state_d = S_ADJUST;
          end else if (start_press) begin
            state_d    = S_RUN;
            tick_cnt_d = '0;
          end
        end
        S_RUN: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            count_en_d = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
          if (start_press) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (adj_lvl) begin
            state_d = S_ADJUST;
          end else if (start_press) begin
            state_d = S_RUN;
          end
        end
        S_ADJUST: begin
          if (!adj_lvl) begin
            state_d = S_PAUSE;
          end else if (start_press) begin
            adj_fire = 1'b1;
          end else if (start_held) begin
            // Auto-repeat while the start button stays held.
            if (adj_cnt_q == ADJ_LAST) begin
              adj_fire = 1'b1;
            end else begin
              adj_cnt_d = adj_cnt_q + ADJ_W'(1);
            end
          end
        end
      endcase
    end

    if (state_q == S_ADJUST) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_d     = blink_q;
      end
    end

    adj_sec_d = adj_fire & ~field_lvl;
    adj_min_d = adj_fire & field_lvl;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      adj_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      count_en_q  <= 1'b0;
      clr_q       <= 1'b0;
      adj_sec_q   <= 1'b0;
      adj_min_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      adj_cnt_q   <= adj_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      count_en_q  <= count_en_d;
      clr_q       <= clr_d;
      adj_sec_q   <= adj_sec_d;
      adj_min_q   <= adj_min_d;
    end
  end

  assign count_en = count_en_q;
  assign clr      = clr_q;
  assign adj_sec  = adj_sec_q;
  assign adj_min  = adj_min_q;
  assign blink    = blink_q | (state_q != S_ADJUST);
  assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl
// Reference model tracks elapsed run/hold/adjust time; monitor pops predicted pulses.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;
  localparam int CLK_HZ = 40, TICK_HZ = 1, ADJ_HZ = 4, BLINK_HZ = 4, DBC = 3;
  localparam int TDIV = CLK_HZ / TICK_HZ;
  localparam int ADIV = CLK_HZ / ADJ_HZ;
  localparam int BDIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ADJ = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_start = 1'b0, btn_clear = 1'b0, sw_adj = 1'b0, sw_field = 1'b0;
  logic count_en, clr, adj_sec, adj_min, blink;
  logic [1:0] state;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ADJ_HZ(ADJ_HZ),
    .BLINK_HZ(BLINK_HZ), .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear),
    .sw_adj(sw_adj), .sw_field(sw_field), .count_en(count_en), .clr(clr),
    .adj_sec(adj_sec), .adj_min(adj_min), .blink(blink), .state(state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit model_on = 1'b0;

  typedef struct { int cyc; logic [3:0] kind; } ev_t;
  ev_t evq[$];

  // Model: raw/debounced level histories plus elapsed-time counters.
  logic [2:0] rh [4];
  logic [2:0] dh [4];
  int         diff_run [4];
  int         mode, run_cycles, held_cycles, adj_cycles, nmode;
  logic       exp_blink;
  logic [1:0] exp_state;
  logic [3:0] m_raw, m_kind;
  logic       m_sp, m_cp, m_adj, m_held, m_fld, m_fire, m_stay, m_new;

  always @(posedge clk) begin
    m_raw = {sw_field, sw_adj, btn_clear, btn_start};
    cyc++;
    if (!rst_n) begin
      model_on = 1'b1;
      for (int i = 0; i < 4; i++) begin
        rh[i] = '0; dh[i] = '0; diff_run[i] = 0;
      end
      mode = M_IDLE; run_cycles = 0; held_cycles = 0; adj_cycles = 0;
    end else begin
      m_sp   = dh[0][1] & ~dh[0][2];
      m_cp   = dh[1][1] & ~dh[1][2];
      m_held = dh[0][0];
      m_adj  = dh[2][0];
      m_fld  = dh[3][0];
      for (int i = 0; i < 4; i++) begin
        m_new = dh[i][0];
        if (rh[i][1] != dh[i][0]) begin
          diff_run[i]++;
          if (diff_run[i] == DBC) begin
            m_new = rh[i][1];
            diff_run[i] = 0;
          end
        end else begin
          diff_run[i] = 0;
        end
        dh[i] = {dh[i][1:0], m_new};
        rh[i] = {rh[i][1:0], m_raw[i]};
      end
      m_kind = '0; m_fire = 1'b0; m_stay = 1'b0; nmode = mode;
      if (m_cp) begin
        m_kind[1] = 1'b1; nmode = M_IDLE; run_cycles = 0;
      end else if (mode == M_IDLE) begin
        if (m_adj) nmode = M_ADJ;
        else if (m_sp) begin nmode = M_RUN; run_cycles = 0; end
      end else if (mode == M_RUN) begin
        run_cycles++;
        if (run_cycles % TDIV == 0) m_kind[0] = 1'b1;
        if (m_sp) nmode = M_PAUSE;
      end else if (mode == M_PAUSE) begin
        if (m_adj) nmode = M_ADJ;
        else if (m_sp) nmode = M_RUN;
      end else begin
        if (!m_adj) nmode = M_PAUSE;
        else begin
          m_stay = 1'b1;
          if (m_sp) begin held_cycles = 0; m_fire = 1'b1; end
          else if (m_held) begin
            held_cycles++;
            m_fire = (held_cycles % ADIV == 0);
          end else held_cycles = 0;
        end
      end
      if (!m_stay) held_cycles = 0;
      if (m_fire) begin
        if (m_fld) m_kind[3] = 1'b1; else m_kind[2] = 1'b1;
      end
      if (mode == M_ADJ) adj_cycles++; else adj_cycles = 0;
      mode = nmode;
      if (m_kind != 4'b0) evq.push_back('{cyc, m_kind});
    end
    exp_state = mode[1:0];
    exp_blink = (mode != M_ADJ) || ((adj_cycles / BDIV) % 2 == 0);
  end

  logic [3:0] dk;
  always @(negedge clk) begin
    if (model_on) begin
      dk = {adj_min, adj_sec, clr, count_en};
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL pulse_missing cyc %0d: got none, expected kind %b at cyc %0d", cyc, evq[0].kind, evq[0].cyc);
        void'(evq.pop_front());
      end
      if (dk !== 4'b0) begin
        checks++;
        if (evq.size() == 0 || evq[0].cyc != cyc) begin
          errors++;
          $display("FAIL pulse_unexpected cyc %0d: got %b, expected 0000", cyc, dk);
        end else begin
          if (dk !== evq[0].kind) begin
            errors++;
            $display("FAIL pulse_kind cyc %0d: got %b, expected %b", cyc, dk, evq[0].kind);
          end
          void'(evq.pop_front());
        end
      end
      checks++;
      if (state !== exp_state) begin
        errors++;
        $display("FAIL state cyc %0d: got %b, expected %b", cyc, state, exp_state);
      end
      checks++;
      if (blink !== exp_blink) begin
        errors++;
        $display("FAIL blink cyc %0d: got %b, expected %b", cyc, blink, exp_blink);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, output int n);
    n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state !== s) begin
      errors++;
      $display("FAIL wait_state timeout: got %b, expected %b", state, s);
    end
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (count_en !== 1'b1 && n < budget);
    checks++;
    if (count_en !== 1'b1) begin
      errors++;
      $display("FAIL wait_tick timeout: got no count_en within %0d cycles", budget);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ticks;
    step(3);
    chk("reset_outputs", {state, blink, count_en, clr, adj_sec, adj_min}, 7'b00_1_0000);
    rst_n = 1'b1;
    step(4);

    // Clean start press: state change at DBC+4, first tick TDIV later.
    btn_start = 1'b1;
    wait_state(2'b01, 30, n);
    chk("start_latency", n, DBC + 4);
    btn_start = 1'b0;
    wait_tick(TDIV + 20, n);
    chk("first_tick", n, TDIV);
    wait_tick(TDIV + 20, n);
    chk("tick_period", n, TDIV);

    // Pause 25 cycles past a tick.
    step(18);
    btn_start = 1'b1;
    step(8);
    btn_start = 1'b0;
    chk("paused", state, M_PAUSE);
    step(10);
    repeat (6) begin
      btn_start = 1'b1; step(1); btn_start = 1'b0; step(2);
    end
    chk("glitch_no_press", state, M_PAUSE);
    step(60);
    btn_start = 1'b1;
    wait_state(2'b01, 30, n);
    btn_start = 1'b0;
    wait_tick(TDIV + 20, n);
    chk("resume_tick", n, TDIV - 25);

    // Pause, then ADJUST with held start and a mid-hold field change.
    btn_start = 1'b1;
    wait_state(2'b10, 30, n);
    btn_start = 1'b0;
    step(10);
    sw_adj = 1'b1; sw_field = 1'b1;
    wait_state(2'b11, 30, n);
    chk("adjust_latency", n, DBC + 3);
    step(3);
    btn_start = 1'b1;
    step(45);
    sw_field = 1'b0;
    step(25);
    btn_start = 1'b0;
    step(20);
    sw_adj = 1'b0;
    wait_state(2'b10, 30, n);

    // Clear and start pressed together during RUN.
    btn_start = 1'b1;
    wait_state(2'b01, 30, n);
    btn_start = 1'b0;
    step(20);
    btn_start = 1'b1; btn_clear = 1'b1;
    wait_state(2'b00, 30, n);
    chk("clear_latency", n, DBC + 4);
    step(3);
    btn_start = 1'b0; btn_clear = 1'b0;
    ticks = 0;
    repeat (TDIV) begin
      @(negedge clk);
      if (count_en) ticks++;
    end
    chk("no_tick_after_clear", ticks, 0);
    chk("idle_after_clear", state, M_IDLE);

    // Reset mid-RUN, then a fresh start.
    btn_start = 1'b1;
    wait_state(2'b01, 30, n);
    btn_start = 1'b0;
    wait_tick(TDIV + 20, n);
    step(30);
    rst_n = 1'b0;
    step(1);
    chk("midrun_reset_outputs", {state, blink, count_en, clr, adj_sec, adj_min}, 7'b00_1_0000);
    rst_n = 1'b1;
    step(2);
    btn_start = 1'b1;
    wait_state(2'b01, 30, n);
    btn_start = 1'b0;
    wait_tick(TDIV + 20, n);
    chk("tick_after_reset", n, TDIV);

    // Randomized stimulus against the model.
    repeat (300) begin
      btn_start = ($urandom_range(0, 2) == 0);
      btn_clear = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) sw_adj = ~sw_adj;
      sw_field = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0; step(1); rst_n = 1'b1;
      end
      step($urandom_range(1, 25));
    end

    btn_start = 1'b0; btn_clear = 1'b0; sw_adj = 1'b0; sw_field = 1'b0;
    step(20);
    while (evq.size() > 0) begin
      checks++; errors++;
      $display("FAIL pulse_leftover: got none, expected kind %b at cyc %0d", evq[0].kind, evq[0].cyc);
      void'(evq.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
